// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit.
// Runs a req/gnt/rvalid data bus, stalls upstream and extends load data.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_busy,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_lsu_exc,
  output logic        o_bus_err,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_be,
  input  logic        i_dbus_gnt,
  input  logic        i_dbus_rvalid,
  input  logic [31:0] i_dbus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        ld_q, ld_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_q, exc_d;
  logic        err_q, err_d;

  logic        is_st, is_ld;
  logic        w_b, w_h, w_w;
  logic        f3_ok, algn_ok, legal;
  logic        req_in, idle, accept, illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_sh, ld_ext;
  logic [7:0]  cnt_inc;

  // Both load and store set means store.
  assign is_st = i_store;
  assign is_ld = i_load & ~i_store;

  assign w_b = i_func3[1:0] == 2'b00;
  assign w_h = i_func3[1:0] == 2'b01;
  assign w_w = i_func3[1:0] == 2'b10;

  assign f3_ok = is_st
    ? (~i_func3[2] & ~&i_func3[1:0])
    : (~&i_func3[1:0] & ~(i_func3[2] & i_func3[1]));

  assign algn_ok = ~(w_h & i_addr[0])
                 & ~(w_w & |i_addr[1:0]);

  assign legal   = f3_ok & algn_ok;
  assign req_in  = i_rst_n & i_valid & (i_load | i_store);
  assign idle    = state_q == S_IDLE;
  assign accept  = idle & req_in & legal;
  assign illegal = idle & req_in & ~legal;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = i_wdata;
    unique case (1'b1)
      w_b: begin
        be_new    = 4'b0001 << i_addr[1:0];
        wdata_new = {4{i_wdata[7:0]}};
      end
      w_h: begin
        be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{i_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = i_wdata;
      end
    endcase
  end

  assign ld_sh = i_dbus_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rd_d      = rd_q;
    ld_d      = ld_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    exc_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          cnt_d   = 8'd0;
          addr_d  = {i_addr[31:2], 2'b00};
          we_d    = is_st;
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = i_func3;
          off_d   = i_addr[1:0];
          rd_d    = i_rd_addr;
          ld_d    = is_ld;
        end else if (illegal) begin
          exc_d = 1'b1;
        end
      end
      S_REQ: begin
        if (i_dbus_gnt && i_dbus_rvalid) begin
          state_d = S_IDLE;
          if (ld_q && rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = ld_ext;
          end
        end else if (i_dbus_gnt) begin
          state_d = S_RESP;
          cnt_d   = 8'd0;
        end else if (cnt_inc == TO_CNT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (i_dbus_rvalid) begin
          state_d = S_IDLE;
          if (ld_q && rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = ld_ext;
          end
        end else if (cnt_inc == TO_CNT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
      ld_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      exc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      ld_q      <= ld_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      exc_q     <= exc_d;
      err_q     <= err_d;
    end
  end

  assign o_busy       = ~idle | accept;
  assign o_wb_en      = wb_en_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;
  assign o_lsu_exc    = exc_q;
  assign o_bus_err    = err_q;
  assign o_dbus_req   = state_q == S_REQ;
  assign o_dbus_we    = we_q;
  assign o_dbus_addr  = addr_q;
  assign o_dbus_wdata = wdata_q;
  assign o_dbus_be    = be_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector bench for mem_lsu.
// Table of accesses plus timeout, reset and back-to-back sequences.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_load, i_store;
  logic [2:0]  i_func3;
  logic [31:0] i_addr, i_wdata;
  logic [4:0]  i_rd_addr;
  logic        o_busy, o_wb_en;
  logic [4:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic        o_lsu_exc, o_bus_err;
  logic        o_dbus_req, o_dbus_we;
  logic [31:0] o_dbus_addr, o_dbus_wdata;
  logic [3:0]  o_dbus_be;
  logic        i_dbus_gnt, i_dbus_rvalid;
  logic [31:0] i_dbus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .i_load(i_load),
    .i_store(i_store),
    .i_func3(i_func3),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .i_rd_addr(i_rd_addr),
    .o_busy(o_busy),
    .o_wb_en(o_wb_en),
    .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data),
    .o_lsu_exc(o_lsu_exc),
    .o_bus_err(o_bus_err),
    .o_dbus_req(o_dbus_req),
    .o_dbus_we(o_dbus_we),
    .o_dbus_addr(o_dbus_addr),
    .o_dbus_wdata(o_dbus_wdata),
    .o_dbus_be(o_dbus_be),
    .i_dbus_gnt(i_dbus_gnt),
    .i_dbus_rvalid(i_dbus_rvalid),
    .i_dbus_rdata(i_dbus_rdata)
  );

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        wb;
    logic [31:0] e_wbd;
    logic        exc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string n, input logic ld, input logic st,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [4:0] rd,
    input int g, input int r, input logic [31:0] rdat,
    input logic bus, input logic [31:0] ea,
    input logic [3:0] be, input logic we,
    input logic cwd, input logic [31:0] ewd,
    input logic wb, input logic [31:0] ewb,
    input logic exc);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.f3 = f3;
    v.addr = a; v.wdata = wd; v.rd = rd;
    v.gdly = g; v.rdly = r; v.rdata = rdat;
    v.bus = bus; v.e_addr = ea; v.e_be = be;
    v.e_we = we; v.chk_wd = cwd; v.e_wd = ewd;
    v.wb = wb; v.e_wbd = ewb; v.exc = exc;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_load = 0; i_store = 0;
    i_func3 = 0; i_addr = 0; i_wdata = 0;
    i_rd_addr = 0;
    i_dbus_gnt = 0; i_dbus_rvalid = 0;
    i_dbus_rdata = 0;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic apply(input vec_t v);
    int busy_n, req_n, wb_n, exc_n, err_n, gc, rc;
    logic granted;
    logic [31:0] c_addr, c_wd, c_wbd;
    logic [3:0] c_be;
    logic c_we;
    logic [4:0] c_wba;
    busy_n = 0; req_n = 0; wb_n = 0;
    exc_n = 0; err_n = 0; gc = 0; rc = 0;
    granted = 0;
    c_addr = 0; c_wd = 0; c_wbd = 0;
    c_be = 0; c_we = 0; c_wba = 0;
    i_valid = 1; i_load = v.ld; i_store = v.st;
    i_func3 = v.f3; i_addr = v.addr;
    i_wdata = v.wdata; i_rd_addr = v.rd;
    @(negedge clk);
    if (o_busy) busy_n++;
    @(posedge clk); #1;
    i_valid = 0; i_load = 0; i_store = 0;
    for (int c = 0; c < 10; c++) begin
      i_dbus_gnt = 0; i_dbus_rvalid = 0;
      i_dbus_rdata = 0;
      if (o_dbus_req) begin
        if (gc == v.gdly) begin
          i_dbus_gnt = 1;
          if (v.rdly == 0) begin
            i_dbus_rvalid = 1;
            i_dbus_rdata = v.rdata;
          end else begin
            granted = 1;
            rc = 1;
          end
        end
        gc++;
      end else if (granted) begin
        if (rc == v.rdly) begin
          i_dbus_rvalid = 1;
          i_dbus_rdata = v.rdata;
          granted = 0;
        end
        rc++;
      end
      @(negedge clk);
      if (o_busy) busy_n++;
      if (o_dbus_req) begin
        req_n++;
        c_addr = o_dbus_addr; c_be = o_dbus_be;
        c_wd = o_dbus_wdata; c_we = o_dbus_we;
      end
      if (o_wb_en) begin
        wb_n++;
        c_wbd = o_wb_data; c_wba = o_wb_addr;
      end
      if (o_lsu_exc) exc_n++;
      if (o_bus_err) err_n++;
      @(posedge clk); #1;
    end
    i_dbus_gnt = 0; i_dbus_rvalid = 0;
    chk({v.name, ".busy_cycles"}, busy_n,
        v.bus ? 2 + v.gdly + v.rdly : 0);
    chk({v.name, ".req_cycles"}, req_n,
        v.bus ? v.gdly + 1 : 0);
    chk({v.name, ".wb_pulses"}, wb_n, 32'(v.wb));
    chk({v.name, ".exc_pulses"}, exc_n, 32'(v.exc));
    chk({v.name, ".err_pulses"}, err_n, 0);
    if (v.bus) begin
      chk({v.name, ".addr"}, c_addr, v.e_addr);
      chk({v.name, ".be"}, 32'(c_be), 32'(v.e_be));
      chk({v.name, ".we"}, 32'(c_we), 32'(v.e_we));
    end
    if (v.chk_wd) chk({v.name, ".wdata"}, c_wd, v.e_wd);
    if (v.wb) begin
      chk({v.name, ".wb_data"}, c_wbd, v.e_wbd);
      chk({v.name, ".wb_addr"}, 32'(c_wba), 32'(v.rd));
    end
  endtask

  initial begin
    int req_n, busy_n, err_n, wb_n;
    idle_inputs();
    rst_n = 0;
    tbl.push_back(mk("lw_100", 1,0,3'b010,32'h100,0,5,2,1,
      32'hDEADBEEF,1,32'h100,4'b1111,0,0,0,1,32'hDEADBEEF,0));
    tbl.push_back(mk("lb_103", 1,0,3'b000,32'h103,0,6,0,0,
      32'h80112233,1,32'h100,4'b1000,0,0,0,1,32'hFFFFFF80,0));
    tbl.push_back(mk("lbu_103",1,0,3'b100,32'h103,0,6,1,0,
      32'h80112233,1,32'h100,4'b1000,0,0,0,1,32'h00000080,0));
    tbl.push_back(mk("lh_102", 1,0,3'b001,32'h102,0,7,0,1,
      32'h80112233,1,32'h100,4'b1100,0,0,0,1,32'hFFFF8011,0));
    tbl.push_back(mk("lhu_102",1,0,3'b101,32'h102,0,7,0,0,
      32'h80112233,1,32'h100,4'b1100,0,0,0,1,32'h00008011,0));
    tbl.push_back(mk("lb_101", 1,0,3'b000,32'h101,0,8,0,3,
      32'h00007F00,1,32'h100,4'b0010,0,0,0,1,32'h0000007F,0));
    tbl.push_back(mk("lh_100", 1,0,3'b001,32'h100,0,9,3,0,
      32'h12348765,1,32'h100,4'b0011,0,0,0,1,32'hFFFF8765,0));
    tbl.push_back(mk("sb_201", 0,1,3'b000,32'h201,32'hAB,3,1,1,
      0,1,32'h200,4'b0010,1,1,32'hABABABAB,0,0,0));
    tbl.push_back(mk("sh_202", 0,1,3'b001,32'h202,32'h1234,3,0,2,
      0,1,32'h200,4'b1100,1,1,32'h12341234,0,0,0));
    tbl.push_back(mk("sw_204", 0,1,3'b010,32'h204,32'hCAFEF00D,3,0,0,
      0,1,32'h204,4'b1111,1,1,32'hCAFEF00D,0,0,0));
    tbl.push_back(mk("ldst_208",1,1,3'b010,32'h208,32'h11223344,12,0,0,
      32'hFFFFFFFF,1,32'h208,4'b1111,1,1,32'h11223344,0,0,0));
    tbl.push_back(mk("lw_102_mis",1,0,3'b010,32'h102,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk("lh_101_mis",1,0,3'b001,32'h101,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk("ld_f3_011",1,0,3'b011,32'h100,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk("ld_f3_110",1,0,3'b110,32'h100,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk("st_f3_100",0,1,3'b100,32'h100,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk("sh_203_mis",0,1,3'b001,32'h203,0,5,0,0,
      0,0,0,0,0,0,0,0,0,1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", o_busy, 0);
    chk("rst.req", o_dbus_req, 0);
    chk("rst.wb_en", o_wb_en, 0);
    chk("rst.wb_data", o_wb_data, 0);
    chk("rst.exc", o_lsu_exc, 0);
    chk("rst.err", o_bus_err, 0);
    chk("rst.be", 32'(o_dbus_be), 0);
    chk("rst.addr", o_dbus_addr, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(tbl[i]);

    // Bus never grants: abort after four REQ cycles.
    i_valid = 1; i_load = 1; i_func3 = 3'b010;
    i_addr = 32'h300; i_rd_addr = 7;
    @(posedge clk); #1;
    i_valid = 0; i_load = 0;
    req_n = 0; busy_n = 0; err_n = 0; wb_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_dbus_req) req_n++;
      if (o_busy) busy_n++;
      if (o_wb_en) wb_n++;
      if (o_bus_err) begin
        err_n++;
        chk("to.req_at_err", o_dbus_req, 0);
        chk("to.busy_at_err", o_busy, 0);
      end
      @(posedge clk); #1;
    end
    chk("to.req_cycles", req_n, 4);
    chk("to.busy_cycles", busy_n, 4);
    chk("to.err_pulses", err_n, 1);
    i_dbus_gnt = 1; i_dbus_rvalid = 1;
    i_dbus_rdata = 32'h12345678;
    @(posedge clk); #1;
    i_dbus_gnt = 0; i_dbus_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_wb_en || o_dbus_req || o_busy) wb_n++;
      @(posedge clk); #1;
    end
    chk("to.stray_activity", wb_n, 0);

    // Back-to-back: second load accepted as busy falls.
    i_valid = 1; i_load = 1; i_func3 = 3'b010;
    i_addr = 32'h10; i_rd_addr = 9;
    @(posedge clk); #1;
    i_valid = 0; i_load = 0;
    i_dbus_gnt = 1; i_dbus_rvalid = 1;
    i_dbus_rdata = 32'h00000055;
    @(negedge clk);
    chk("b2b.req1", o_dbus_req, 1);
    @(posedge clk); #1;
    i_dbus_gnt = 0; i_dbus_rvalid = 0;
    i_valid = 1; i_load = 1; i_func3 = 3'b000;
    i_addr = 32'h11; i_rd_addr = 10;
    @(negedge clk);
    chk("b2b.wb1_en", o_wb_en, 1);
    chk("b2b.wb1_data", o_wb_data, 32'h55);
    chk("b2b.busy_accept", o_busy, 1);
    @(posedge clk); #1;
    i_valid = 0; i_load = 0;
    i_dbus_gnt = 1; i_dbus_rvalid = 1;
    i_dbus_rdata = 32'h0000AA00;
    @(negedge clk);
    chk("b2b.req2", o_dbus_req, 1);
    chk("b2b.addr2", o_dbus_addr, 32'h10);
    @(posedge clk); #1;
    i_dbus_gnt = 0; i_dbus_rvalid = 0;
    @(negedge clk);
    chk("b2b.wb2_en", o_wb_en, 1);
    chk("b2b.wb2_data", o_wb_data, 32'hFFFFFFAA);
    chk("b2b.wb2_addr", 32'(o_wb_addr), 10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b.wb_hold", o_wb_data, 32'hFFFFFFAA);
    chk("b2b.wb_off", o_wb_en, 0);
    @(posedge clk); #1;

    // Reset while waiting for the response.
    i_valid = 1; i_load = 1; i_func3 = 3'b010;
    i_addr = 32'h40; i_rd_addr = 4;
    @(posedge clk); #1;
    i_valid = 0; i_load = 0;
    i_dbus_gnt = 1;
    @(posedge clk); #1;
    i_dbus_gnt = 0;
    chk("rresp.busy_before", o_busy, 1);
    rst_n = 0;
    #1;
    chk("rresp.req", o_dbus_req, 0);
    chk("rresp.busy", o_busy, 0);
    chk("rresp.wb_en", o_wb_en, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    apply(mk("lw_rd0", 1,0,3'b010,32'h44,0,0,0,1,
      32'h99,1,32'h44,4'b1111,0,0,0,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage load/store unit; consumes the EX→MEM pipeline register contents (effective address, store data, rd index, access type).
- Drives the data bus with a req/gnt/rvalid handshake and stalls the pipeline while a transaction is outstanding.
- For loads, extracts and sign/zero-extends the returned data and issues a one-cycle register-file write-back.
- Flags misaligned or illegal-width accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: cycles waited in REQ or RESP before aborting with a bus error. Legal range 1..255; the counter is 8 bits.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  pipeline register holds a valid instruction
- i_load  in  1  instruction is a load
- i_store  in  1  instruction is a store
- i_func3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective byte address computed by EX
- i_wdata  in  32  store data (rs2)
- i_rd_addr  in  5  load destination register
- o_busy  out  1  stall request to upstream stages
- o_wb_en  out  1  register-file write strobe, one cycle
- o_wb_addr  out  5  write-back register index
- o_wb_data  out  32  extended load data
- o_lsu_exc  out  1  misaligned or illegal-width pulse, one cycle
- o_bus_err  out  1  timeout pulse, one cycle
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  1 = write
- o_dbus_addr  out  32  word address: {addr[31:2], 2'b00}
- o_dbus_wdata  out  32  lane-replicated store data
- o_dbus_be  out  4  byte enables
- i_dbus_gnt  in  1  request accepted
- i_dbus_rvalid  in  1  response valid (loads and stores)
- i_dbus_rdata  in  32  read data

Behaviour:
- Clock/reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset mid-transaction drops o_dbus_req immediately and discards the pending access.
- FSM states and transitions:
  - IDLE → REQ on accept. Accept condition: i_valid & (i_load | i_store) & legal.
  - REQ: o_dbus_req=1. Address, we, be and wdata are held stable from registered values until i_dbus_gnt.
  - REQ → RESP on gnt without rvalid.
  - REQ → IDLE on gnt & rvalid in the same cycle (completes).
  - RESP → IDLE on i_dbus_rvalid.
- Accept cycle: o_busy=1 combinationally. o_busy=1 in REQ and RESP, and 0 in the cycle after completion, so upstream advances.
- Legality:
  - H/HU require addr[0]=0; W requires addr[1:0]=0.
  - func3 011/110/111 on a load is illegal; func3 ≥011 on a store is illegal.
  - An illegal access gives o_lsu_exc=1 for one cycle, with no bus activity, o_busy=0 and no write-back.
- If i_load & i_store are both set, the access is treated as a store.
- Store lanes (a = addr[1:0]):
  - SB: be = 4'b0001<<a; wdata = byte replicated ×4.
  - SH: be = a[1] ? 1100 : 0011; wdata = halfword replicated ×2.
  - SW: be = 1111.
- Loads:
  - Load be values match the corresponding store widths.
  - Data extraction: shifted = rdata >> (8*a), then extended per func3.
- Write-back: o_wb_en pulses the cycle after the completing rvalid, for loads with rd≠0 only. o_wb_addr and o_wb_data are valid during that pulse and hold their value afterwards. Stores never write back.
- Timeout:
  - The counter clears on entry to REQ and on REQ→RESP, and counts every cycle in REQ or RESP.
  - When it reaches TIMEOUT: o_bus_err pulses, req drops, state returns to IDLE, there is no write-back, and o_busy deasserts the next cycle.
- Stray or late rvalid/gnt seen in IDLE is ignored.
- Back-to-back: a new access can be accepted in the same cycle that o_busy falls, i.e. the IDLE cycle after completion. Minimum load latency is 3 cycles from accept to wb_en (accept, REQ with gnt+rvalid, wb).

Test Plan:
- LW at 0x100, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF → dbus_addr 0x100, be 1111, wb_en once with data 0xDEADBEEF to rd=5, busy high throughout.
- LB at 0x103 and LBU at 0x103, rdata 0x80112233 → wb_data 0xFFFFFF80 and 0x00000080; LH/LHU at 0x102 → 0xFFFF8011 and 0x00008011.
- SB at 0x201 with rs2 0x000000AB → be 0010, wdata 0xABABABAB, we=1; SH at 0x202 with 0x1234 → be 1100, wdata 0x12341234; no wb_en.
- LW at 0x102 and LH at 0x101 → lsu_exc one-cycle pulse, dbus_req never asserted, busy 0.
- TIMEOUT=4, gnt never returned → bus_err pulses after 4 REQ cycles, req drops, busy low next cycle; a later rvalid is ignored with no wb_en.
- Reset asserted in RESP → req/busy/wb_en 0 immediately; after release, LW to rd=0 completes with wb_en never asserted.
